// File: rtl/arith_pkg.sv
// Shared types and size helpers for the arithmetic-result byte serializer.
package arith_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_e;

  // Bytes per 2*width-bit result.
  function automatic int unsigned nb_bytes(input int unsigned width);
    return (2 * width) / 8;
  endfunction

  // Byte-index width; kept at least 1 bit so the index register always exists.
  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of Depth entries with push/pop, registered full flag and occupancy count.
module result_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntW-1:0]      count_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full_q, full_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(Depth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/arith_result_serializer.sv
// Buffers ALU results flagged by Arith_Flag and streams them out LSB byte first over
// a valid/ready byte interface, flagging results dropped on a full buffer.
module arith_result_serializer
  import arith_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic signed [2*Width-1:0]   Arith_OUT,
  input  logic                        Arith_Flag,
  input  logic                        Clear,
  input  logic                        Byte_Ready,
  output logic [7:0]                  Byte_OUT,
  output logic                        Byte_Valid,
  output logic                        Byte_Last,
  output logic                        Fifo_Full,
  output logic                        Overrun
);

  localparam int unsigned RW      = 2 * Width;
  localparam int unsigned NB      = nb_bytes(Width);
  localparam int unsigned IdxW    = idx_width(NB);
  localparam int unsigned CntW    = $clog2(Depth + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

  ser_state_e      state_q, state_d;
  logic [RW-1:0]   shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            overrun_q, overrun_d;

  logic            push, pop, drop;
  logic [RW-1:0]   head;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;

  // Capture decision uses the start-of-cycle count: no pop bypass when full.
  assign push = Arith_Flag && (fifo_count < CntW'(Depth));
  assign drop = Arith_Flag && !(fifo_count < CntW'(Depth));

  result_fifo #(
    .DataWidth (RW),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .wdata_i (Arith_OUT),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (Fifo_Full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (LastIdx == '0);
          state_d = StSend;
        end
      end
      StSend: begin
        if (valid_q && Byte_Ready) begin
          if (idx_q != LastIdx) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IdxW'(1);
            last_d  = ((idx_q + IdxW'(1)) == LastIdx);
          end else if (!fifo_empty) begin
            // Chain straight into the next result so the stream has no bubble.
            pop     = 1'b1;
            shift_d = head;
            idx_d   = '0;
            last_d  = (LastIdx == '0);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A drop in the same cycle as Clear keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (Clear) overrun_d = 1'b0;
    if (drop)  overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign Byte_OUT   = shift_q[7:0];
  assign Byte_Valid = valid_q;
  assign Byte_Last  = last_q;
  assign Overrun    = overrun_q;

endmodule
